// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter onto a byte-enable RAM via accept/access/respond pipeline; define MEM_ARB_RR_EN for round-robin instead of fixed M1 priority
module ram_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [3:0]            m0_sel,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [3:0]            m1_sel,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,
    input  logic                  m1_lock,
    output logic                  ram_w_en,
    output logic [3:0]            ram_sel,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    output logic [31:0]           ram_data_in,
    input  logic [31:0]           ram_data_out
);
    typedef enum logic {UNLOCKED, LOCKED} lock_t;
    lock_t state, state_nx;
    logic m0_wins, any_gnt;
    logic a_vld, a_id, a_we;
    logic [3:0] a_sel;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic [31:0] a_wdata;
    logic r_vld, r_id;
    logic [31:0] r_rdata;

    assign any_gnt = m0_gnt | m1_gnt;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;
    // remember the last granted master so the other one wins the next tie
    always_ff @(posedge clk or posedge rst)
        if (rst) rr_ptr <= 1'b0;
        else if (any_gnt) rr_ptr <= m1_gnt;
    assign m0_wins = rr_ptr;
`else
    localparam int CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0] burst_cnt;
    // count M1 grants that kept a requesting M0 waiting, saturating at the limit
    always_ff @(posedge clk or posedge rst)
        if (rst) burst_cnt <= '0;
        else if (m0_gnt || !m0_req) burst_cnt <= '0;
        else if (m1_gnt && burst_cnt != CW'(MAX_BURST)) burst_cnt <= burst_cnt + 1'b1;
    assign m0_wins = burst_cnt == CW'(MAX_BURST);
`endif

    // lock state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= UNLOCKED;
        else state <= state_nx;

    // lock engages on a locked M1 grant and releases once m1_lock is seen low
    always_comb
        state_nx = (state == LOCKED) ? (m1_lock ? LOCKED : UNLOCKED) : ((m1_gnt && m1_lock) ? LOCKED : UNLOCKED);

    // grants: lock shuts M0 out, otherwise a contested cycle goes to M1 unless M0 is owed it
    always_comb begin
        m0_gnt = !rst && m0_req && state == UNLOCKED && (!m1_req || m0_wins);
        m1_gnt = !rst && m1_req && (state == LOCKED || !m0_req || !m0_wins);
    end

    // accept stage: winner's fields enter the access stage; address/data hold while idle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            a_vld   <= 1'b0;
            a_id    <= 1'b0;
            a_we    <= 1'b0;
            a_sel   <= '0;
            a_addr  <= '0;
            a_wdata <= '0;
        end else begin
            a_vld <= any_gnt;
            if (any_gnt) begin
                a_id    <= m1_gnt;
                a_we    <= m1_gnt ? m1_we : m0_we;
                a_sel   <= m1_gnt ? m1_sel : m0_sel;
                a_addr  <= m1_gnt ? m1_addr : m0_addr;
                a_wdata <= m1_gnt ? m1_wdata : m0_wdata;
            end
        end

    // respond stage: capture read data from the RAM, writes answer with zero
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_vld   <= 1'b0;
            r_id    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_vld <= a_vld;
            if (a_vld) begin
                r_id    <= a_id;
                r_rdata <= a_we ? 32'h0 : ram_data_out;
            end
        end

    assign ram_w_en    = a_vld & a_we;
    assign ram_sel     = a_vld ? a_sel : 4'h0;
    assign ram_w_addr  = a_addr;
    assign ram_r_addr  = a_addr;
    assign ram_data_in = a_wdata;
    assign m0_rvalid   = r_vld & ~r_id;
    assign m1_rvalid   = r_vld & r_id;
    assign m0_rdata    = m0_rvalid ? r_rdata : 32'h0;
    assign m1_rdata    = m1_rvalid ? r_rdata : 32'h0;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized bench for ram_arbiter against a transaction-level model
module tb_ram_arbiter;
    localparam int AW = 10;
    localparam int MB = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
    logic [3:0] m0_sel = 0, m1_sel = 0;
    logic [AW-1:0] m0_addr = 0, m1_addr = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0;
    logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_w_en;
    logic [31:0] m0_rdata, m1_rdata, ram_data_in, ram_data_out;
    logic [3:0] ram_sel;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic pre_en = 0;
    logic [AW-1:0] pre_addr = 0;
    logic [31:0] pre_data = 0;
    logic [31:0] mem [1024];
    logic [31:0] shadow [1024];
    int checks = 0, failures = 0, cyc = 0;
    typedef struct { int due; bit id; logic [31:0] data; } rsp_t;
    rsp_t q[$];
    bit locked, last_id, pend_w, g0, g1;
    int streak;
    logic [AW-1:0] pend_addr;
    logic [3:0] pend_sel;
    logic [31:0] pend_data;

    ram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
        .ram_w_en(ram_w_en), .ram_sel(ram_sel), .ram_w_addr(ram_w_addr), .ram_r_addr(ram_r_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bmerge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
        for (int b = 0; b < 4; b++) if (sel[b]) old[8*b +: 8] = nw[8*b +: 8];
        return old;
    endfunction

    // external RAM: async read, byte-masked sync write, plus a preload port for the bench
    assign ram_data_out = mem[ram_r_addr];
    always @(posedge clk)
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_w_en) mem[ram_w_addr] <= bmerge(mem[ram_w_addr], ram_data_in, ram_sel);

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic poke(logic [AW-1:0] a, logic [31:0] d);
        pre_en = 1; pre_addr = a; pre_data = d; shadow[a] = d;
        @(posedge clk);
        @(negedge clk);
        pre_en = 0;
    endtask

    task automatic model_reset();
        q.delete();
        locked = 0; streak = 0; last_id = 0; pend_w = 0; g0 = 0; g1 = 0;
    endtask

    task automatic set0(bit req, bit we, logic [3:0] sel, logic [AW-1:0] a, logic [31:0] d);
        m0_req = req; m0_we = we; m0_sel = sel; m0_addr = a; m0_wdata = d;
    endtask

    task automatic set1(bit req, bit we, logic [3:0] sel, logic [AW-1:0] a, logic [31:0] d);
        m1_req = req; m1_we = we; m1_sel = sel; m1_addr = a; m1_wdata = d;
    endtask

    // one cycle: check outputs against the model, then advance the model across the edge
    task automatic tick();
        rsp_t e;
        bit hit, id, we;
        logic [AW-1:0] a;
        #1;
        hit = q.size() > 0 && q[0].due == cyc;
        if (hit) e = q.pop_front();
        check("m0_rvalid", m0_rvalid, hit && e.id == 0);
        check("m1_rvalid", m1_rvalid, hit && e.id == 1);
        check("m0_rdata", m0_rdata, (hit && e.id == 0) ? e.data : 32'h0);
        check("m1_rdata", m1_rdata, (hit && e.id == 1) ? e.data : 32'h0);
        check("ram_w_en", ram_w_en, pend_w);
        if (pend_w) begin
            check("ram_w_addr", ram_w_addr, pend_addr);
            check("ram_sel", ram_sel, pend_sel);
            check("ram_data_in", ram_data_in, pend_data);
        end
        if (locked) begin
            g0 = 0; g1 = m1_req;
        end else if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
            g0 = last_id;
`else
            g0 = streak >= MB;
`endif
            g1 = !g0;
        end else begin
            g0 = m0_req; g1 = m1_req;
        end
        check("m0_gnt", m0_gnt, g0);
        check("m1_gnt", m1_gnt, g1);
        @(posedge clk);
        if (pend_w) shadow[pend_addr] = bmerge(shadow[pend_addr], pend_data, pend_sel);
        pend_w = 0;
        if (g0 || g1) begin
            id = g1;
            we = id ? m1_we : m0_we;
            a = id ? m1_addr : m0_addr;
            q.push_back('{cyc + 2, id, we ? 32'h0 : shadow[a]});
            if (we) begin
                pend_w = 1; pend_addr = a;
                pend_sel = id ? m1_sel : m0_sel;
                pend_data = id ? m1_wdata : m0_wdata;
            end
            last_id = id;
        end
        if (g0 || !m0_req) streak = 0;
        else if (g1) streak++;
        locked = locked ? m1_lock : (g1 && m1_lock);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive_rand(int pct);
        if (!m0_req || g0)
            set0($urandom_range(99) < pct, 1'($urandom), 4'($urandom), AW'($urandom_range(15)), $urandom);
        if (!m1_req || g1)
            set1($urandom_range(99) < pct, 1'($urandom), 4'($urandom), AW'($urandom_range(15)), $urandom);
        m1_lock = m1_lock ? ($urandom_range(3) != 0) : ($urandom_range(15) == 0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 16; i++) poke(AW'(i), $urandom);
        poke(5, 32'hDEADBEEF);
        poke(3, 32'h11223344);
        set0(1, 1, 4'hF, 2, 32'h55);
        set1(1, 1, 4'hF, 4, 32'h66);
        #1;
        check("rst_m0_gnt", m0_gnt, 0);
        check("rst_m1_gnt", m1_gnt, 0);
        check("rst_m0_rvalid", m0_rvalid, 0);
        check("rst_m1_rvalid", m1_rvalid, 0);
        check("rst_ram_w_en", ram_w_en, 0);
        check("rst_ram_sel", ram_sel, 0);
        check("rst_ram_w_addr", ram_w_addr, 0);
        check("rst_ram_data_in", ram_data_in, 0);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 0;
        // single M0 read of a preloaded word
        set0(1, 0, 4'hF, 5, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        repeat (3) tick();
        // M1 partial write followed by read-back
        set1(1, 1, 4'b0010, 3, 32'h0000AB00);
        tick();
        set1(1, 0, 4'hF, 3, 0);
        tick();
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();
        check("t2_ram3", mem[3], 32'h1122AB44);
        // both masters request continuously
        set0(1, 0, 4'hF, 1, 0);
        set1(1, 0, 4'hF, 2, 0);
        repeat (12) tick();
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();
        // M1 holds the lock while M0 waits
        set1(1, 0, 4'hF, 6, 0);
        m1_lock = 1;
        tick();
        set0(1, 0, 4'hF, 4, 0);
        repeat (3) tick();
        m1_lock = 0;
        set1(0, 0, 0, 0, 0);
        repeat (2) tick();
        set0(0, 0, 0, 0, 0);
        repeat (3) tick();
        // reset lands in the access cycle of a write
        set1(1, 1, 4'hF, 7, 32'hCAFEF00D);
        tick();
        set1(0, 0, 0, 0, 0);
        check("t5_wen_before", ram_w_en, 1);
        rst = 1;
        #1;
        check("t5_wen_in_rst", ram_w_en, 0);
        check("t5_sel_in_rst", ram_sel, 0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 0;
        repeat (3) tick();
        check("t5_ram7", mem[7], shadow[7]);
        // back-to-back interleaved reads and writes, one grant per cycle
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                set0(1, i % 4 == 0, 4'($urandom), AW'(8 + i / 2), $urandom);
                set1(0, 0, 0, 0, 0);
            end else begin
                set0(0, 0, 0, 0, 0);
                set1(1, i % 4 == 3, 4'($urandom), AW'(8 + (i - 1) / 2), $urandom);
            end
            tick();
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        repeat (3) tick();
        // randomized traffic including locks
        for (int i = 0; i < 3000; i++) begin
            drive_rand(60);
            tick();
        end
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        m1_lock = 0;
        repeat (4) tick();
        for (int i = 0; i < 16; i++) check("ram_final", mem[i], shadow[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
